// File: rtl/player_move_ctrl.sv
// Grid-stepping player controller: validates each move through an external
// collision check, and handles death, respawn and game-over sequencing.
module player_move_ctrl #(
    parameter int H_START       = 320,
    parameter int V_START       = 456,
    parameter int H_MIN         = 128,
    parameter int H_MAX         = 500,
    parameter int V_MIN         = 12,
    parameter int V_MAX         = 456,
    parameter int STEP          = 12,
    parameter int LIVES         = 3,
    parameter int RESPAWN_TICKS = 32
) (
    input  logic       slowClk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] btns,
    input  logic       hazard,
    output logic       chk_req,
    output logic [9:0] chk_h,
    output logic [9:0] chk_v,
    input  logic       chk_ack,
    input  logic       chk_blocked,
    output logic [9:0] hPos,
    output logic [9:0] vPos,
    output logic       player_dead,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CHECK, DEAD, OVER} state_t;

    localparam int TW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [TW-1:0]      TICK_LAST = TW'(RESPAWN_TICKS - 1);
    localparam logic signed [10:0] STEP_S    = 11'(STEP);
    localparam logic signed [10:0] H_MIN_S   = 11'(H_MIN);
    localparam logic signed [10:0] H_MAX_S   = 11'(H_MAX);
    localparam logic signed [10:0] V_MIN_S   = 11'(V_MIN);
    localparam logic signed [10:0] V_MAX_S   = 11'(V_MAX);

    state_t          state_q, state_d;
    logic [9:0]      hpos_q, hpos_d, vpos_q, vpos_d;
    logic [9:0]      chk_h_q, chk_h_d, chk_v_q, chk_v_d;
    logic            chk_req_q, chk_req_d;
    logic            dead_q, dead_d;
    logic            over_q, over_d;
    logic            busy_q, busy_d;
    logic [1:0]      lives_q, lives_d;
    logic [3:0]      wdg_q, wdg_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;

    logic signed [10:0] tgt_h_s, tgt_v_s;
    logic               in_range_s;
    logic               hit_s;

    // Candidate target for the highest-priority requested direction
    always_comb begin
        tgt_h_s = $signed({1'b0, hpos_q});
        tgt_v_s = $signed({1'b0, vpos_q});
        if (btns[3]) begin
            tgt_v_s = $signed({1'b0, vpos_q}) - STEP_S;
        end else if (btns[2]) begin
            tgt_v_s = $signed({1'b0, vpos_q}) + STEP_S;
        end else if (btns[1]) begin
            tgt_h_s = $signed({1'b0, hpos_q}) - STEP_S;
        end else if (btns[0]) begin
            tgt_h_s = $signed({1'b0, hpos_q}) + STEP_S;
        end else begin
            tgt_h_s = $signed({1'b0, hpos_q});
        end
        in_range_s = (tgt_h_s >= H_MIN_S) && (tgt_h_s <= H_MAX_S) &&
                     (tgt_v_s >= V_MIN_S) && (tgt_v_s <= V_MAX_S);
    end

    // Next-state logic; a hazard while alive pre-empts everything, including an ack
    always_comb begin
        state_d    = state_q;
        hpos_d     = hpos_q;
        vpos_d     = vpos_q;
        chk_h_d    = chk_h_q;
        chk_v_d    = chk_v_q;
        chk_req_d  = chk_req_q;
        dead_d     = dead_q;
        over_d     = over_q;
        lives_d    = lives_q;
        wdg_d      = wdg_q;
        tick_cnt_d = tick_cnt_q;
        hit_s      = hazard && ((state_q == IDLE) || (state_q == CHECK));

        if (hit_s) begin
            state_d    = DEAD;
            dead_d     = 1'b1;
            chk_req_d  = 1'b0;
            lives_d    = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick && (btns != 4'b0000) && in_range_s) begin
                        chk_h_d   = tgt_h_s[9:0];
                        chk_v_d   = tgt_v_s[9:0];
                        chk_req_d = 1'b1;
                        wdg_d     = 4'd0;
                        state_d   = CHECK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CHECK: begin
                    if (chk_ack) begin
                        chk_req_d = 1'b0;
                        state_d   = IDLE;
                        if (!chk_blocked) begin
                            hpos_d = chk_h_q;
                            vpos_d = chk_v_q;
                        end else begin
                            hpos_d = hpos_q;
                        end
                    end else if (wdg_q == 4'd14) begin
                        // Fifteenth unanswered cycle: give up, treat as blocked
                        chk_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        wdg_d = wdg_q + 4'd1;
                    end
                end
                DEAD: begin
                    if (tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            if (lives_q != 2'd0) begin
                                hpos_d  = 10'(H_START);
                                vpos_d  = 10'(V_START);
                                dead_d  = 1'b0;
                                state_d = IDLE;
                            end else begin
                                over_d  = 1'b1;
                                state_d = OVER;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + TW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d == CHECK);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge slowClk) begin
        if (rst) begin
            state_q    <= IDLE;
            hpos_q     <= 10'(H_START);
            vpos_q     <= 10'(V_START);
            chk_h_q    <= 10'd0;
            chk_v_q    <= 10'd0;
            chk_req_q  <= 1'b0;
            dead_q     <= 1'b0;
            over_q     <= 1'b0;
            busy_q     <= 1'b0;
            lives_q    <= 2'(LIVES);
            wdg_q      <= 4'd0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            chk_h_q    <= chk_h_d;
            chk_v_q    <= chk_v_d;
            chk_req_q  <= chk_req_d;
            dead_q     <= dead_d;
            over_q     <= over_d;
            busy_q     <= busy_d;
            lives_q    <= lives_d;
            wdg_q      <= wdg_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign hPos        = hpos_q;
    assign vPos        = vpos_q;
    assign chk_h       = chk_h_q;
    assign chk_v       = chk_v_q;
    assign chk_req     = chk_req_q;
    assign player_dead = dead_q;
    assign game_over   = over_q;
    assign busy        = busy_q;
    assign lives       = lives_q;

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 SHALL have parameter H_START, default 320, meaning the player's horizontal spawn pixel.
REQ-002 SHALL have parameter V_START, default 456, meaning the player's vertical spawn pixel.
REQ-003 SHALL have parameters H_MIN/H_MAX, defaults 128/500, meaning the inclusive horizontal position bounds.
REQ-004 SHALL have parameters V_MIN/V_MAX, defaults 12/456, meaning the inclusive vertical position bounds.
REQ-005 SHALL have parameter STEP, default 12, meaning pixels moved per step (one grid cell).
REQ-006 SHALL have parameter LIVES, default 3, meaning the lives loaded at reset (range 1-3).
REQ-007 SHALL have parameter RESPAWN_TICKS, default 32, meaning the number of tick pulses spent dead before respawn.
REQ-008 SHALL have port slowClk, input, 1, the single clock; all logic is rising-edge.
REQ-009 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-010 SHALL have port tick, input, 1, a one-cycle movement strobe.
REQ-011 SHALL have port btns, input, 4, move request: bit3 up, bit2 down, bit1 left, bit0 right.
REQ-012 SHALL have port hazard, input, 1, indicating the current player cell overlaps a hazard.
REQ-013 SHALL have ports chk_req (output, 1), chk_h (output, 10) and chk_v (output, 10), forming the collision-check request and target pixel.
REQ-014 SHALL have ports chk_ack (input, 1) and chk_blocked (input, 1), forming the check response, valid when chk_ack=1.
REQ-015 SHALL have ports hPos (output, 10) and vPos (output, 10), giving the registered player position.
REQ-016 SHALL have ports player_dead (output, 1), lives (output, 2), game_over (output, 1) and busy (output, 1).

Function
REQ-017 SHALL implement FSM states IDLE, CHECK, DEAD and OVER; busy=1 exactly in CHECK.
REQ-018 In IDLE on tick=1 with any btns bit set, SHALL select one direction by priority up>down>left>right.
REQ-019 SHALL compute the target as the position -/+STEP on the selected axis (up=vPos-STEP, down=vPos+STEP, left=hPos-STEP, right=hPos+STEP), evaluated in 11-bit signed arithmetic.
REQ-020 If the target lies outside [MIN,MAX] on its axis, SHALL stay in IDLE, issue no request and leave the position unchanged.
REQ-021 Otherwise SHALL register chk_h/chk_v=target, assert chk_req next cycle and enter CHECK.
REQ-022 In CHECK SHALL hold chk_req, chk_h and chk_v stable until a cycle with chk_ack=1; chk_req SHALL drop the cycle after that ack.
REQ-023 On ack with chk_blocked=0, SHALL load hPos/vPos=target on the same edge and return to IDLE; on ack with chk_blocked=1, SHALL return to IDLE with no move.
REQ-024 SHALL run a 4-bit watchdog in CHECK; after 15 cycles without ack it SHALL drop chk_req, return to IDLE and treat the check as blocked.
REQ-025 SHALL ignore tick and btns while in CHECK, DEAD and OVER; no requests are queued.
REQ-026 On hazard=1 in IDLE or CHECK, SHALL enter DEAD on the next edge, set player_dead=1, drop chk_req, decrement lives (saturating at 0) and zero the tick counter.
REQ-027 On hazard coinciding with chk_ack, hazard SHALL win and no move SHALL occur.
REQ-028 In DEAD SHALL count tick pulses; on the RESPAWN_TICKS-th tick, if lives>0 it SHALL load hPos=H_START and vPos=V_START, clear player_dead and enter IDLE.
REQ-029 On the RESPAWN_TICKS-th tick with lives=0, SHALL enter OVER; in OVER, game_over=1 and player_dead=1, and the block SHALL hold until rst.
REQ-030 SHALL ignore hazard while in DEAD and OVER.

Reset
REQ-031 With rst=1 at a rising edge, SHALL set: state=IDLE, hPos=H_START, vPos=V_START, lives=LIVES, chk_req=0, chk_h=0, chk_v=0, player_dead=0, game_over=0, busy=0, counters=0.
REQ-032 Reset SHALL take priority over all inputs and SHALL abort any CHECK, DEAD or OVER state immediately.

Verification
REQ-033 Post-reset tick with btns=4'b1000, ack with blocked=0 after 3 cycles -> chk_v=444, chk_req high for 4 cycles, vPos=444 and hPos=320 after the ack edge.
REQ-034 Post-reset tick with btns=4'b0100 (vPos=456=V_MAX) -> no chk_req, position unchanged; repeat with btns=4'b1100 -> up wins, chk_v=444.
REQ-035 chk_req pending with chk_ack never asserted -> chk_req drops after 15 cycles, state returns to IDLE, position unchanged.
REQ-036 hazard pulse in the same cycle as chk_ack with blocked=0 -> no move, player_dead=1, lives 3->2; after 32 ticks, position=(320,456) and player_dead=0.
REQ-037 Three hazard deaths, each followed by 32 ticks -> lives=0, game_over=1; further ticks and btns are ignored; rst restores lives=3 and game_over=0.
